// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions: write-back source encodings and register index constants.
package wb_regfile_pkg;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_LINK = 2'b10,
    WB_SEL_NONE = 2'b11
  } wb_sel_e;
endpackage

// File: rtl/wb_regfile_mux.sv
// 4:1 write-back value select; standalone so the forwarding unit can reuse it.
module wb_mux
  import wb_regfile_pkg::*;
(
  input  wb_sel_e           sel_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_i,
  input  logic [DATA_W-1:0] link_i,
  output logic [DATA_W-1:0] val_o
);
  always_comb begin
    val_o = '0;
    unique case (sel_i)
      WB_SEL_ALU:  val_o = alu_i;
      WB_SEL_MEM:  val_o = mem_i;
      WB_SEL_LINK: val_o = link_i;
      WB_SEL_NONE: val_o = '0;
      default:     val_o = '0;
    endcase
  end
endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: source select, 32-entry register file with write-through
// bypass on both read ports, and a committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mem_to_reg,
  input  logic                 reg_write,
  input  logic [DATA_W-1:0]    mem_data,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic [DATA_W-1:0]    link_addr,
  input  logic [REG_IDX_W-1:0] wb_dest,
  input  logic [REG_IDX_W-1:0] rd_addr1,
  input  logic [REG_IDX_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]    rd_data1,
  output logic [DATA_W-1:0]    rd_data2,
  output logic [DATA_W-1:0]    wb_value,
  output logic                 wb_we,
  output logic [DATA_W-1:0]    wr_count
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] wr_count_q, wr_count_d;
  wb_sel_e           sel;

  assign sel = wb_sel_e'(mem_to_reg);

  wb_mux u_wb_mux (
    .sel_i  (sel),
    .alu_i  (alu_result),
    .mem_i  (mem_data),
    .link_i (link_addr),
    .val_o  (wb_value)
  );

  assign wb_we      = reg_write && (sel != WB_SEL_NONE) && (wb_dest != REG_ZERO);
  assign wr_count_d = wb_we ? wr_count_q + 32'd1 : wr_count_q;
  assign wr_count   = wr_count_q;

  // Register 0 is hard-wired to zero on the read side regardless of storage.
  function automatic logic [DATA_W-1:0] rd_port(input logic [REG_IDX_W-1:0] addr);
    if (addr == REG_ZERO)            return '0;
    else if (wb_we && addr == wb_dest) return wb_value;
    else                             return regs_q[addr];
  endfunction

  assign rd_data1 = rd_port(rd_addr1);
  assign rd_data2 = rd_port(rd_addr2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      if (wb_we) regs_q[wb_dest] <= wb_value;
      wr_count_q <= wr_count_d;
    end
  end
endmodule
